// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// State encoding is visible to debug through the stall/halted outputs.
package hazard_unit_pkg;

  localparam int NB_REG = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Operand/destination bundle seen by the hazard detector.
// master drives the register fields, slave returns the stall demand.
interface hazard_unit_if #(
  parameter int NB_REG = 5
);

  logic [NB_REG-1:0] id_rs;
  logic [NB_REG-1:0] id_rt;
  logic              use_rs;
  logic              use_rt;
  logic              id_branch;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [NB_REG-1:0] ex_rd;
  logic              mem_mem_read;
  logic [NB_REG-1:0] mem_rd;
  logic [1:0]        demand;

  modport master (
    output id_rs, id_rt, use_rs, use_rt,
    output id_branch,
    output ex_mem_read, ex_reg_write, ex_rd,
    output mem_mem_read, mem_rd,
    input  demand
  );

  modport slave (
    input  id_rs, id_rt, use_rs, use_rt,
    input  id_branch,
    input  ex_mem_read, ex_reg_write, ex_rd,
    input  mem_mem_read, mem_rd,
    output demand
  );

endinterface

// File: rtl/hazard_unit_detect.sv
// Combinational stall-demand computation (0, 1 or 2 cycles).
// Register 0 is hardwired, so it never produces a match.
module hazard_detect (
  hazard_unit_if.slave hz
);

  logic ex_rs, ex_rt, ex_match;
  logic mem_rs, mem_rt, mem_match;
  logic need1;

  always_comb begin
    ex_rs  = hz.use_rs && (hz.id_rs == hz.ex_rd);
    ex_rt  = hz.use_rt && (hz.id_rt == hz.ex_rd);
    ex_match = (hz.ex_rd != '0) && (ex_rs || ex_rt);

    mem_rs = hz.use_rs && (hz.id_rs == hz.mem_rd);
    mem_rt = hz.use_rt && (hz.id_rt == hz.mem_rd);
    mem_match = (hz.mem_rd != '0) && (mem_rs || mem_rt);

    need1 = (hz.ex_mem_read && ex_match)
         || (hz.id_branch && hz.ex_reg_write
             && ex_match)
         || (hz.id_branch && hz.mem_mem_read
             && mem_match);

    hz.demand = 2'd0;
    if (hz.ex_mem_read && ex_match
        && hz.id_branch)
      hz.demand = 2'd2;
    else if (need1)
      hz.demand = 2'd1;
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard sequencer: stalls, bubbles, branch flush and halt drain.
// Detection is combinational; the FSM only tracks multi-cycle work.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int NB_REG       = hazard_unit_pkg::NB_REG,
  parameter int DRAIN_CYCLES = 4,
  parameter int NB_CNT       = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [NB_REG-1:0] IF_ID_Rs,
  input  logic [NB_REG-1:0] IF_ID_Rt,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic              i_id_branch,
  input  logic              i_branch_taken,
  input  logic              i_jump,
  input  logic              i_halt,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_RegWrite,
  input  logic [NB_REG-1:0] ID_EX_Rd,
  input  logic              EX_MEM_MemRead,
  input  logic [NB_REG-1:0] EX_MEM_Rd,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_id_ex_bubble,
  output logic              o_if_id_flush,
  output logic              o_stall,
  output logic              o_halted
);

  localparam logic [NB_CNT-1:0] DRAIN_CNT =
    NB_CNT'(DRAIN_CYCLES - 1);
  localparam logic [NB_CNT-1:0] ONE =
    NB_CNT'(1);

  hazard_unit_if #(.NB_REG(NB_REG)) hz ();

  assign hz.id_rs        = IF_ID_Rs;
  assign hz.id_rt        = IF_ID_Rt;
  assign hz.use_rs       = i_id_uses_rs;
  assign hz.use_rt       = i_id_uses_rt;
  assign hz.id_branch    = i_id_branch;
  assign hz.ex_mem_read  = ID_EX_MemRead;
  assign hz.ex_reg_write = ID_EX_RegWrite;
  assign hz.ex_rd        = ID_EX_Rd;
  assign hz.mem_mem_read = EX_MEM_MemRead;
  assign hz.mem_rd       = EX_MEM_Rd;

  hazard_detect u_detect (
    .hz (hz)
  );

  state_e            state_q, state_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_id_ex_bubble = 1'b0;
    o_if_id_flush  = 1'b0;
    o_stall        = 1'b0;
    o_halted       = (state_q == ST_HALTED);

    if (!i_rst_n) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b1;
      o_halted       = 1'b0;
    end else if (!i_enable) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_stall       = (state_q == ST_STALL);
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hz.demand != 2'd0) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_bubble = 1'b1;
            o_stall        = 1'b1;
            if (hz.demand == 2'd2) begin
              state_d = ST_STALL;
              cnt_d   = ONE;
            end
          end else if (i_halt) begin
            // HALT itself still moves on to EX
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            if (DRAIN_CYCLES > 1) begin
              state_d = ST_DRAIN;
              cnt_d   = DRAIN_CNT;
            end else begin
              state_d = ST_HALTED;
            end
          end else begin
            o_if_id_flush = i_branch_taken | i_jump;
          end
        end
        ST_STALL: begin
          o_pc_write     = 1'b0;
          o_if_id_write  = 1'b0;
          o_id_ex_bubble = 1'b1;
          o_stall        = 1'b1;
          cnt_d          = cnt_q - ONE;
          if (cnt_q <= ONE) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_DRAIN: begin
          o_pc_write     = 1'b0;
          o_if_id_write  = 1'b0;
          o_id_ex_bubble = 1'b1;
          cnt_d          = cnt_q - ONE;
          if (cnt_q <= ONE) begin
            state_d = ST_HALTED;
            cnt_d   = '0;
          end
        end
        ST_HALTED: begin
          o_pc_write     = 1'b0;
          o_if_id_write  = 1'b0;
          o_id_ex_bubble = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table plus
// multi-cycle sequences for stall, enable, halt and reset.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic halt = 1'b0;
  logic tk = 1'b0;
  logic jmp = 1'b0;

  logic pc_w, ifid_w, bub, flush, stall, halted;
  logic [5:0] outs;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] O_QUIET  = 6'b110000;
  localparam logic [5:0] O_STALL  = 6'b001010;
  localparam logic [5:0] O_FLUSH  = 6'b110100;
  localparam logic [5:0] O_RESET  = 6'b001000;
  localparam logic [5:0] O_DRAIN  = 6'b001000;
  localparam logic [5:0] O_HALTED = 6'b001001;
  localparam logic [5:0] O_FROZEN = 6'b000010;

  hazard_unit_if #(.NB_REG(5)) bus ();

  always #5 clk = ~clk;

  hazard_unit #(
    .NB_REG       (5),
    .DRAIN_CYCLES (4),
    .NB_CNT       (3)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (en),
    .IF_ID_Rs       (bus.id_rs),
    .IF_ID_Rt       (bus.id_rt),
    .i_id_uses_rs   (bus.use_rs),
    .i_id_uses_rt   (bus.use_rt),
    .i_id_branch    (bus.id_branch),
    .i_branch_taken (tk),
    .i_jump         (jmp),
    .i_halt         (halt),
    .ID_EX_MemRead  (bus.ex_mem_read),
    .ID_EX_RegWrite (bus.ex_reg_write),
    .ID_EX_Rd       (bus.ex_rd),
    .EX_MEM_MemRead (bus.mem_mem_read),
    .EX_MEM_Rd      (bus.mem_rd),
    .o_pc_write     (pc_w),
    .o_if_id_write  (ifid_w),
    .o_id_ex_bubble (bub),
    .o_if_id_flush  (flush),
    .o_stall        (stall),
    .o_halted       (halted)
  );

  assign bus.demand = 2'd0;
  assign outs = {pc_w, ifid_w, bub, flush, stall, halted};

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       tk;
    logic       jmp;
    logic       exmr;
    logic       exrw;
    logic [4:0] exrd;
    logic       memmr;
    logic [4:0] memrd;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic check_m(input string nm,
                         input logic [5:0] mask,
                         input logic [5:0] exp);
    tests++;
    if ((outs & mask) !== (exp & mask)) begin
      fails++;
      $display("FAIL %s: got %b want %b (mask %b)",
               nm, outs, exp, mask);
    end
  endtask

  task automatic check(input string nm,
                       input logic [5:0] exp);
    check_m(nm, 6'b111111, exp);
  endtask

  task automatic quiet();
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.use_rs       = 1'b0;
    bus.use_rt       = 1'b0;
    bus.id_branch    = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_reg_write = 1'b0;
    bus.ex_rd        = '0;
    bus.mem_mem_read = 1'b0;
    bus.mem_rd       = '0;
    tk   = 1'b0;
    jmp  = 1'b0;
    halt = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.id_rs        = v.rs;
    bus.id_rt        = v.rt;
    bus.use_rs       = v.urs;
    bus.use_rt       = v.urt;
    bus.id_branch    = v.br;
    tk               = v.tk;
    jmp              = v.jmp;
    bus.ex_mem_read  = v.exmr;
    bus.ex_reg_write = v.exrw;
    bus.ex_rd        = v.exrd;
    bus.mem_mem_read = v.memmr;
    bus.mem_rd       = v.memrd;
    halt             = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_branch_hazard();
    quiet();
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd9;
    bus.id_branch   = 1'b1;
    bus.id_rt       = 5'd9;
    bus.use_rt      = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // rs rt urs urt br tk jmp exmr exrw exrd memmr memrd exp
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_QUIET};
    tbl[1]  = '{8, 0, 1, 0, 0, 0, 0, 1, 0, 8, 0, 0, O_STALL};
    tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_QUIET};
    tbl[3]  = '{8, 0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, O_QUIET};
    tbl[4]  = '{1, 7, 1, 1, 0, 0, 0, 1, 1, 7, 0, 0, O_STALL};
    tbl[5]  = '{3, 0, 1, 0, 1, 0, 0, 0, 1, 3, 0, 0, O_STALL};
    tbl[6]  = '{3, 0, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0, O_QUIET};
    tbl[7]  = '{0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 5, O_STALL};
    tbl[8]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, O_QUIET};
    tbl[9]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, O_FLUSH};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, O_FLUSH};
    tbl[11] = '{3, 0, 1, 0, 1, 1, 0, 0, 1, 3, 0, 0, O_STALL};
    tbl[12] = '{5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5, O_QUIET};
    tbl[13] = '{4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4, O_QUIET};

    quiet();
    #2;
    check("reset_hold", O_RESET);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", O_QUIET);

    for (int i = 0; i < 14; i++) begin
      step();
      apply(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // load feeding a branch: two stall cycles, flush held off
    step();
    ld_branch_hazard();
    tk = 1'b1;
    @(negedge clk);
    check("ldbr_c1", O_STALL);
    step();
    @(negedge clk);
    check("ldbr_c2", O_STALL);
    step();
    bus.ex_mem_read = 1'b0;
    @(negedge clk);
    check("ldbr_resolve", O_FLUSH);
    step();
    quiet();
    @(negedge clk);
    check("ldbr_after", O_QUIET);

    // ALU result feeding a branch: one stall, then flush
    step();
    bus.ex_reg_write = 1'b1;
    bus.ex_rd        = 5'd3;
    bus.id_branch    = 1'b1;
    bus.id_rs        = 5'd3;
    bus.use_rs       = 1'b1;
    @(negedge clk);
    check("alubr_stall", O_STALL);
    step();
    bus.ex_reg_write = 1'b0;
    tk = 1'b1;
    @(negedge clk);
    check("alubr_flush", O_FLUSH);
    step();
    quiet();
    @(negedge clk);
    check("alubr_after", O_QUIET);

    // freeze in the middle of a two-cycle stall
    step();
    ld_branch_hazard();
    @(negedge clk);
    check("frz_stall1", O_STALL);
    step();
    quiet();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("frz_hold%0d", i), O_FROZEN);
      step();
    end
    en = 1'b1;
    @(negedge clk);
    check("frz_resume", O_STALL);
    step();
    @(negedge clk);
    check("frz_done", O_QUIET);

    // halt drain: four cycles to HALTED
    step();
    halt = 1'b1;
    @(negedge clk);
    check_m("halt_entry", 6'b110111, 6'b000000);
    step();
    halt = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("drain_t%0d", i), O_DRAIN);
      step();
    end
    @(negedge clk);
    check("halted_t4", O_HALTED);
    step();
    ld_branch_hazard();
    tk = 1'b1;
    @(negedge clk);
    check("halted_hold", O_HALTED);
    quiet();
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_halted", O_RESET);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("run_after_halted", O_QUIET);

    // asynchronous reset while draining
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    @(negedge clk);
    check("drain_before_rst", O_DRAIN);
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_drain", O_RESET);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("run_after_drain", O_QUIET);
    step();
    @(negedge clk);
    check("run_stays", O_QUIET);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
